// File: rtl/acs_scheduler.sv
// Viterbi trellis-step controller for a K=3, rate-1/2 code.
// One shared ACS evaluates one next-state per cycle over ping-pong metric banks.
module acs_scheduler #(
    parameter logic [2:0] G0          = 3'b111,
    parameter logic [2:0] G1          = 3'b101,
    parameter int unsigned NORM_THRESH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [1:0]  sym,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [3:0]  dec_bits,
    output logic [3:0]  dec_mask,
    output logic [1:0]  best_state,
    output logic [31:0] pm_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT,
        OUT
    } state_e;

    localparam logic [7:0] THR = NORM_THRESH[7:0];

    state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] sym_q, sym_d;
    logic       bank_q, bank_d;
    logic [1:0][3:0][7:0] pm_q, pm_d;
    logic [1:0][3:0]      vld_q, vld_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  dec_bits_q, dec_bits_d;
    logic [3:0]  dec_mask_q, dec_mask_d;
    logic [1:0]  best_q, best_d;
    logic [31:0] pm_out_q, pm_out_d;

    logic       nb;
    logic [1:0] p0, p1;
    logic [1:0] bm0, bm1;
    logic       v0, v1;
    logic [8:0] sum0, sum1, acs_sum;
    logic       acs_sel, acs_v;

    logic [7:0]      min_v;
    logic            any_v, do_norm;
    logic [1:0]      best_v;
    logic [3:0][7:0] norm;

    function automatic logic [1:0] branch_metric(
        input logic       u,
        input logic [1:0] s,
        input logic [1:0] r
    );
        logic [2:0] reg3;
        logic [1:0] d;
        reg3 = {u, s};
        d = {^(G0 & reg3), ^(G1 & reg3)} ^ r;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    assign nb = ~bank_q;

    // Predecessors of next-state {n1,n0} are {n0,0} and {n0,1}; input bit is n1.
    always_comb begin
        p0   = {idx_q[0], 1'b0};
        p1   = {idx_q[0], 1'b1};
        bm0  = branch_metric(idx_q[1], p0, sym_q);
        bm1  = branch_metric(idx_q[1], p1, sym_q);
        v0   = vld_q[bank_q][p0];
        v1   = vld_q[bank_q][p1];
        sum0 = {1'b0, pm_q[bank_q][p0]} + {7'd0, bm0};
        sum1 = {1'b0, pm_q[bank_q][p1]} + {7'd0, bm1};
        if (v0 && v1) begin
            acs_sel = (sum1 < sum0);
        end else begin
            acs_sel = ~v0 & v1;
        end
        acs_sum = acs_sel ? sum1 : sum0;
        acs_v   = v0 | v1;
    end

    // Minimum search doubles as best-state pick: strict compare keeps lowest index.
    always_comb begin
        min_v  = '1;
        any_v  = 1'b0;
        best_v = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (vld_q[nb][i] && (!any_v || pm_q[nb][i] < min_v)) begin
                min_v  = pm_q[nb][i];
                any_v  = 1'b1;
                best_v = 2'(i);
            end
        end
        do_norm = any_v && (min_v >= THR);
        for (int i = 0; i < 4; i++) begin
            if (!vld_q[nb][i]) begin
                norm[i] = '0;
            end else if (do_norm) begin
                norm[i] = pm_q[nb][i] - THR;
            end else begin
                norm[i] = pm_q[nb][i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sym_d      = sym_q;
        bank_d     = bank_q;
        pm_d       = pm_q;
        vld_d      = vld_q;
        sel_d      = sel_q;
        dec_bits_d = dec_bits_q;
        dec_mask_d = dec_mask_q;
        best_d     = best_q;
        pm_out_d   = pm_out_q;
        unique case (state_q)
            IDLE: begin
                if (sym_valid) begin
                    sym_d   = sym;
                    idx_d   = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                pm_d[nb][idx_q]  = acs_sum[7:0];
                vld_d[nb][idx_q] = acs_v;
                sel_d[idx_q]     = acs_sel;
                idx_d            = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                pm_d[nb]   = norm;
                bank_d     = nb;
                dec_bits_d = sel_q;
                dec_mask_d = vld_q[nb];
                best_d     = best_v;
                pm_out_d   = norm;
                state_d    = OUT;
            end
            OUT: begin
                if (dec_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            sym_q      <= 2'd0;
            bank_q     <= 1'b0;
            pm_q       <= '0;
            vld_q      <= 8'b0000_0001;
            sel_q      <= 4'd0;
            dec_bits_q <= 4'd0;
            dec_mask_q <= 4'b0001;
            best_q     <= 2'd0;
            pm_out_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sym_q      <= sym_d;
            bank_q     <= bank_d;
            pm_q       <= pm_d;
            vld_q      <= vld_d;
            sel_q      <= sel_d;
            dec_bits_q <= dec_bits_d;
            dec_mask_q <= dec_mask_d;
            best_q     <= best_d;
            pm_out_q   <= pm_out_d;
        end
    end

    assign sym_ready  = (state_q == IDLE);
    assign dec_valid  = (state_q == OUT);
    assign dec_bits   = dec_bits_q;
    assign dec_mask   = dec_mask_q;
    assign best_state = best_q;
    assign pm_out     = pm_out_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        (state_q == RUN && acs_v) |-> !acs_sum[8]);

endmodule

// File: tb/tb_acs_scheduler.sv
// Directed bench for acs_scheduler: hand-computed trellis vectors, handshake
// corner cases and a forward-form golden model for the normalization run.
module tb_acs_scheduler;

    logic        clk = 1'b0;
    logic        rst, flush, sym_valid, dec_ready;
    logic [1:0]  sym;
    logic        sym_ready, dec_valid;
    logic [3:0]  dec_bits, dec_mask;
    logic [1:0]  best_state;
    logic [31:0] pm_out;

    always #5 clk = ~clk;

    acs_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym        (sym),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_bits   (dec_bits),
        .dec_mask   (dec_mask),
        .best_state (best_state),
        .pm_out     (pm_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          do_rst;
        logic [1:0]  sym;
        logic [3:0]  bits;
        logic [3:0]  mask;
        logic [1:0]  best;
        logic [31:0] pm;
    } vec_t;

    vec_t vecs[7];

    // Golden model: unnormalized integer metrics, forward trellis walk.
    int       gm[4];
    bit       gv[4];
    int       offset;
    int       norm_events;
    bit [3:0] m_bits;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            gm[i] = 0;
            gv[i] = (i == 0);
        end
        offset = 0;
    endtask

    task automatic model_step(input logic [1:0] r);
        int       nm[4];
        bit       nv[4];
        bit [3:0] bits;
        int       mn;
        bit       anyv;
        bits = '0;
        for (int n = 0; n < 4; n++) begin
            nm[n] = 0;
            nv[n] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            if (gv[s]) begin
                for (int u = 0; u < 2; u++) begin
                    int ns, cost;
                    bit c1, c0;
                    ns   = u * 2 + s / 2;
                    c1   = u[0] ^ s[1] ^ s[0];
                    c0   = u[0] ^ s[0];
                    cost = gm[s] + int'(c1 != r[1]) + int'(c0 != r[0]);
                    if (!nv[ns] || cost < nm[ns]) begin
                        nm[ns]   = cost;
                        nv[ns]   = 1;
                        bits[ns] = s[0];
                    end
                end
            end
        end
        mn = 0;
        anyv = 0;
        for (int n = 0; n < 4; n++) begin
            gm[n] = nm[n];
            gv[n] = nv[n];
            if (nv[n] && (!anyv || nm[n] - offset < mn)) begin
                mn = nm[n] - offset;
                anyv = 1;
            end
        end
        if (anyv && mn >= 128) begin
            offset += 128;
            norm_events++;
        end
        m_bits = bits;
    endtask

    task automatic check_model(input string nm);
        logic [31:0] epm;
        logic [3:0]  emask;
        logic [1:0]  ebest;
        int          mn;
        bit          anyv;
        epm = '0;
        emask = '0;
        ebest = '0;
        anyv = 0;
        mn = 0;
        for (int i = 0; i < 4; i++) begin
            if (gv[i]) begin
                epm[i*8 +: 8] = 8'(gm[i] - offset);
                emask[i] = 1'b1;
                if (!anyv || gm[i] < mn) begin
                    mn = gm[i];
                    anyv = 1;
                    ebest = 2'(i);
                end
            end
        end
        chk({nm, "_valid"}, 32'(dec_valid), 32'd1);
        chk({nm, "_bits"}, 32'(dec_bits), 32'(m_bits));
        chk({nm, "_mask"}, 32'(dec_mask), 32'(emask));
        chk({nm, "_best"}, 32'(best_state), 32'(ebest));
        chk({nm, "_pm"}, pm_out, epm);
    endtask

    // All tasks start and end at a negative clock edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_dec(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!dec_valid && lat < 20);
    endtask

    task automatic send_sym(input logic [1:0] s, output int lat);
        chk("sym_ready_idle", 32'(sym_ready), 32'd1);
        sym_valid = 1'b1;
        sym = s;
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        wait_dec(lat);
    endtask

    task automatic release_dec();
        dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          hi_cnt;
        bit          stable;
        logic [3:0]  cap_bits;
        logic [31:0] cap_pm;
        int          steps;
        int          after;

        vecs[0] = '{1'b1, 2'b00, 4'b0000, 4'b0101, 2'd0, 32'h0002_0000};
        vecs[1] = '{1'b1, 2'b11, 4'b0000, 4'b0101, 2'd2, 32'h0000_0002};
        vecs[2] = '{1'b0, 2'b10, 4'b0000, 4'b1111, 2'd1, 32'h0203_0003};
        vecs[3] = '{1'b0, 2'b00, 4'b1111, 4'b1111, 2'd2, 32'h0300_0302};
        vecs[4] = '{1'b0, 2'b01, 4'b0000, 4'b1111, 2'd3, 32'h0003_0203};
        vecs[5] = '{1'b0, 2'b11, 4'b1011, 4'b1111, 2'd1, 32'h0103_0102};
        vecs[6] = '{1'b0, 2'b10, 4'b1101, 4'b1111, 2'd3, 32'h0102_0302};

        norm_events = 0;
        rst = 1'b1;
        flush = 1'b0;
        sym_valid = 1'b0;
        sym = 2'b00;
        dec_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_sym_ready", 32'(sym_ready), 32'd1);
        chk("rst_dec_bits", 32'(dec_bits), 32'd0);
        chk("rst_dec_mask", 32'(dec_mask), 32'b0001);
        chk("rst_best", 32'(best_state), 32'd0);
        chk("rst_pm", pm_out, 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_rst) do_reset();
            send_sym(vecs[i].sym, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd5);
            chk($sformatf("v%0d_bits", i), 32'(dec_bits), 32'(vecs[i].bits));
            chk($sformatf("v%0d_mask", i), 32'(dec_mask), 32'(vecs[i].mask));
            chk($sformatf("v%0d_best", i), 32'(best_state), 32'(vecs[i].best));
            chk($sformatf("v%0d_pm", i), pm_out, vecs[i].pm);
            model_step(vecs[i].sym);
            release_dec();
            chk($sformatf("v%0d_drop", i), 32'(dec_valid), 32'd0);
        end

        // Back-pressure in OUT with a pending symbol.
        send_sym(2'b01, lat);
        model_step(2'b01);
        check_model("stall_first");
        cap_bits = dec_bits;
        cap_pm = pm_out;
        sym_valid = 1'b1;
        sym = 2'b11;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!dec_valid || dec_bits !== cap_bits || pm_out !== cap_pm
                || sym_ready) stable = 1'b0;
        end
        chk("stall_stable", 32'(stable), 32'd1);
        dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec_ready = 1'b0;
        chk("stall_drop", 32'(dec_valid), 32'd0);
        chk("stall_not_taken", 32'(sym_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        chk("stall_taken", 32'(sym_ready), 32'd0);
        wait_dec(lat);
        chk("stall_lat", 32'(lat), 32'd5);
        model_step(2'b11);
        check_model("stall_second");
        release_dec();

        // Random symbols until metrics cross the normalization threshold.
        do_reset();
        steps = 0;
        after = 0;
        while (steps < 1500 && after < 4) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            send_sym(s, lat);
            model_step(s);
            check_model($sformatf("rnd%0d", steps));
            if (norm_events > 0) after++;
            release_dec();
            steps++;
        end
        chk("norm_seen", 32'(norm_events > 0), 32'd1);

        // Flush during RUN idx=2.
        sym_valid = 1'b1;
        sym = 2'b10;
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (dec_valid) hi_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("flush_no_valid", 32'(hi_cnt), 32'd0);
        chk("flush_sym_ready", 32'(sym_ready), 32'd1);
        chk("flush_pm", pm_out, 32'd0);
        chk("flush_mask", 32'(dec_mask), 32'b0001);
        model_reset();
        send_sym(vecs[0].sym, lat);
        chk("flush_v0_lat", 32'(lat), 32'd5);
        chk("flush_v0_bits", 32'(dec_bits), 32'(vecs[0].bits));
        chk("flush_v0_mask", 32'(dec_mask), 32'(vecs[0].mask));
        chk("flush_v0_best", 32'(best_state), 32'(vecs[0].best));
        chk("flush_v0_pm", pm_out, vecs[0].pm);
        model_step(vecs[0].sym);
        release_dec();

        // Reset while a decision is held in OUT.
        do_reset();
        send_sym(2'b11, lat);
        chk("orst_valid", 32'(dec_valid), 32'd1);
        chk("orst_pm_before", pm_out, 32'h0000_0002);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("orst_dec_valid", 32'(dec_valid), 32'd0);
        chk("orst_sym_ready", 32'(sym_ready), 32'd1);
        chk("orst_pm", pm_out, 32'd0);
        chk("orst_mask", 32'(dec_mask), 32'b0001);
        chk("orst_bits", 32'(dec_bits), 32'd0);
        chk("orst_best", 32'(best_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
